maxpool2d_2x2_s2: RTL and testbench

Streaming 2×2 max-pooling layer with stride 2 for the CNN accelerator datapath. It takes one IEEE-754 binary32 feature-map element per cycle in raster order, for a square IMG_SIZE×IMG_SIZE channel. It emits one pooled element per 2×2 window, giving an (IMG_SIZE/2)×(IMG_SIZE/2) output in raster order. It sits between a convolution/activation stage and the next layer's input stream.

---
 rtl/maxpool2d_2x2_s2.sv | 89 ++++++++
 tb/tb_maxpool2d_2x2_s2.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_2x2_s2.sv
// Streaming 2x2 stride-2 max pooling over a square binary32 feature map in raster order.
// Even rows fold pairs into a line buffer; odd rows finish each window and emit it.
module maxpool2d_2x2_s2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 416
) (
    input  logic                  Clk,
    input  logic                  Rst,
    // valid_in qualifies data_in for one cycle; there is no ready, so every
    // valid_out pulse must be consumed by the downstream stage on that cycle.
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int HALF = IMG_SIZE / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CW   = HW + 1;
    localparam int MSB  = DATA_WIDTH - 1;

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic [DATA_WIDTH-1:0] pair;
    logic [DATA_WIDTH-1:0] linebuf [HALF];
    logic [HW-1:0]         lb_idx;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] win_max;
    logic                  last_col;
    logic                  last_row;
    logic                  win_done;

    // Sign-magnitude total order: positive beats negative, larger magnitude
    // wins among positives, smaller magnitude wins among negatives.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic a_gt;
        if (a[MSB] != b[MSB]) begin
            a_gt = ~a[MSB];
        end else if (!a[MSB]) begin
            a_gt = a[MSB-1:0] > b[MSB-1:0];
        end else begin
            a_gt = a[MSB-1:0] < b[MSB-1:0];
        end
        return a_gt ? a : b;
    endfunction

    assign lb_idx   = col[CW-1:1];
    assign pair_max = fmax(pair, data_in);
    assign win_max  = fmax(pair_max, linebuf[lb_idx]);
    assign last_col = (col == CW'(IMG_SIZE - 1));
    assign last_row = (row == CW'(IMG_SIZE - 1));
    assign win_done = valid_in && row[0] && col[0];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col       <= '0;
            row       <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= win_done;
            if (win_done) begin
                data_out <= win_max;
            end
            if (valid_in) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Pair register and line buffer carry no reset; their contents are always
    // rewritten before being read within a window.
    always_ff @(posedge Clk) begin
        if (valid_in) begin
            if (!col[0]) begin
                pair <= data_in;
            end else if (!row[0]) begin
                linebuf[lb_idx] <= pair_max;
            end
        end
    end

endmodule

// File: tb/tb_maxpool2d_2x2_s2.sv
// Bench for maxpool2d_2x2_s2 at IMG_SIZE=4: directed frames, stalls, back-to-back
// frames and resets, checked every cycle against a window-level model.
module tb_maxpool2d_2x2_s2;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_out;
    logic [DW-1:0] data_out;

    int            errors = 0;
    int            checks = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    logic          pend_valid = 1'b0;
    logic [DW-1:0] exp_hold = '0;
    logic [DW-1:0] cur [N*N];
    int            pos = 0;

    logic [DW-1:0] ramp [16] = '{
        32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
        32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
        32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
        32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
    logic [DW-1:0] ramp_exp [4] = '{32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000};
    logic [DW-1:0] sign_frame [16] = '{
        32'hBF800000, 32'hC0000000, 32'h80000000, 32'h00000000,
        32'hBF000000, 32'hC0400000, 32'hBF800000, 32'hC0000000,
        32'hBF800000, 32'h3F000000, 32'h7FC00000, 32'h3F800000,
        32'hC0000000, 32'hC0000000, 32'hFF800000, 32'h00000001};
    logic [DW-1:0] sign_exp [4] = '{32'hBF000000, 32'h00000000, 32'h3F000000, 32'h7FC00000};

    maxpool2d_2x2_s2 #(.DATA_WIDTH(DW), .IMG_SIZE(N)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 Clk = ~Clk;

    // Map each bit pattern onto an unsigned key whose natural order is the pooling order.
    function automatic logic [DW-1:0] order_key(input logic [DW-1:0] x);
        return x[DW-1] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [DW-1:0] model_max4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [DW-1:0] best;
        best = a;
        if (order_key(b) > order_key(best)) best = b;
        if (order_key(c) > order_key(best)) best = c;
        if (order_key(d) > order_key(best)) best = d;
        return best;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle; accepted elements feed the model, which predicts the pulse.
    task automatic step(input logic v, input logic [DW-1:0] d);
        int r;
        int c;
        @(negedge Clk);
        valid_in   = v;
        data_in    = d;
        pend_valid = 1'b0;
        if (v) begin
            cur[pos] = d;
            r = pos / N;
            c = pos % N;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                pend_valid = 1'b1;
                exp_q.push_back(model_max4(cur[(r-1)*N + c-1], cur[(r-1)*N + c],
                                           cur[r*N + c-1], cur[r*N + c]));
            end
            pos = (pos + 1) % (N*N);
        end
    endtask

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            Rst        = 1'b0;
            valid_in   = 1'b1;
            data_in    = $urandom();
            pend_valid = 1'b0;
        end
        @(negedge Clk);
        Rst      = 1'b1;
        valid_in = 1'b0;
        pos      = 0;
        exp_q.delete();
    endtask

    task automatic send_frame(input logic [DW-1:0] f [16], input int stall_max);
        for (int i = 0; i < 16; i++) begin
            for (int s = $urandom_range(0, stall_max); s > 0; s--) step(1'b0, $urandom());
            step(1'b1, f[i]);
        end
    endtask

    task automatic flush();
        step(1'b0, $urandom());
        step(1'b0, $urandom());
    endtask

    task automatic check_obs(input string name, input logic [DW-1:0] e [4], input int reps);
        checks++;
        if (obs_q.size() != 4*reps) begin
            errors++;
            $display("FAIL %s_count: got %0d pulses, required %0d", name, obs_q.size(), 4*reps);
        end else begin
            for (int i = 0; i < 4*reps; i++) check(name, obs_q[i], e[i % 4]);
        end
        obs_q.delete();
    endtask

    // Per-cycle compare, sampled 1 time unit after the rising edge.
    always @(posedge Clk) begin
        #1;
        if (!Rst) begin
            check("reset_valid", {31'b0, valid_out}, 32'd0);
            check("reset_data", data_out, 32'h0);
            exp_hold = '0;
        end else if (pend_valid) begin
            check("pulse_valid", {31'b0, valid_out}, 32'd1);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL model_queue: got empty, required one entry");
            end else begin
                exp_hold = exp_q.pop_front();
                check("pulse_data", data_out, exp_hold);
            end
            if (valid_out) obs_q.push_back(data_out);
        end else begin
            check("idle_valid", {31'b0, valid_out}, 32'd0);
            check("hold_data", data_out, exp_hold);
            if (valid_out) obs_q.push_back(data_out);
        end
    end

    initial begin
        #1 Rst = 1'b0;
        // Pin the model against hand-computed windows.
        check("model_w0", model_max4(32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000), 32'hBF000000);
        check("model_w1", model_max4(32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000), 32'h00000000);
        check("model_w2", model_max4(32'hBF800000, 32'h3F000000, 32'hC0000000, 32'hC0000000), 32'h3F000000);
        check("model_ramp", model_max4(ramp[10], ramp[11], ramp[14], ramp[15]), 32'h41700000);

        hold_reset(5);
        send_frame(ramp, 0);
        flush();
        check_obs("ramp", ramp_exp, 1);

        send_frame(ramp, 2);
        flush();
        check_obs("stall", ramp_exp, 1);

        send_frame(ramp, 0);
        send_frame(ramp, 0);
        flush();
        check_obs("b2b", ramp_exp, 2);

        for (int i = 0; i < 6; i++) step(1'b1, ramp[15 - i]);
        hold_reset(2);
        obs_q.delete();
        send_frame(ramp, 1);
        flush();
        check_obs("midreset", ramp_exp, 1);

        send_frame(sign_frame, 1);
        flush();
        check_obs("signs", sign_exp, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule
